store_buffer: RTL and testbench

Write-buffering load/store front end placed between the execute stage and `Data_Memory`. Stores are queued in a small FIFO and drained to memory one per cycle when the port is free. Loads take priority over draining, are forwarded from the youngest matching queued store, and trigger a full drain only when they partially overlap queued data. The memory-side outputs drive `Data_Memory`'s `ALU_Result`, `WriteMemData`, `MemWrite` and `MemRead` directly.

---
 rtl/store_buffer.sv | 160 ++++++++++++++++
 tb/tb_store_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// Store buffer between execute and Data_Memory: queues stores, forwards loads.
// Define STORE_BUF_FWD_EN to build store-to-load forwarding and overlap checks.
//
// state | meaning
// IDLE  | accept loads; otherwise drain head entry to memory
// RD    | memory read of the pending load address
// RESP  | ld_done pulse, ld_data from forward register or mem_rdata
// FLUSH | drain entries present at load acceptance, then RD
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RD, RESP, FLUSH} state_t;

  state_t              state;
  logic [3:0]          ent_addr [DEPTH];
  logic [DATA_W-1:0]   ent_data [DEPTH];
  logic [AW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic [CW-1:0]       flush_cnt;
  logic [3:0]          ld_addr_q;
  logic [DATA_W-1:0]   fwd_q;
  logic                use_fwd;
  logic [DATA_W-1:0]   ld_data_q;

  logic                push, pop;
  logic                fwd_hit, need_flush;
  logic [DATA_W-1:0]   fwd_data;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[31:4], ld_addr[31:4]};

  assign st_ready  = (count < CW'(DEPTH));
  assign ld_ready  = (state == IDLE);
  assign push      = st_valid && st_ready;
  assign mem_write = ((state == IDLE) && !ld_valid && (count != '0)) ||
                     ((state == FLUSH) && (flush_cnt != '0));
  assign mem_read  = (state == RD);
  assign pop       = mem_write;
  assign mem_addr  = mem_write ? {28'h0, ent_addr[head]} :
                     mem_read  ? {28'h0, ld_addr_q} : 32'h0;
  assign mem_wdata = mem_write ? ent_data[head] : '0;
  assign ld_done   = (state == RESP);
  assign ld_data   = ld_done ? (use_fwd ? fwd_q : mem_rdata) : ld_data_q;

`ifdef STORE_BUF_FWD_EN
  logic [AW-1:0] idx;
  logic [3:0]    diff;

  // Walk oldest to youngest: an exact match clears any older overlap.
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    need_flush = 1'b0;
    idx        = '0;
    diff       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = head + AW'(i);
      diff = (ent_addr[idx] > ld_addr[3:0]) ? (ent_addr[idx] - ld_addr[3:0])
                                            : (ld_addr[3:0] - ent_addr[idx]);
      if (CW'(i) < count) begin
        if (ent_addr[idx] == ld_addr[3:0]) begin
          fwd_hit    = 1'b1;
          fwd_data   = ent_data[idx];
          need_flush = 1'b0;
        end else if (diff < 4'd8) begin
          need_flush = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    need_flush = (count != '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[3:0];
      ent_data[tail] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flush_cnt <= '0;
      ld_addr_q <= '0;
      fwd_q     <= '0;
      use_fwd   <= 1'b0;
      ld_data_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE: begin
          if (ld_valid) begin
            ld_addr_q <= ld_addr[3:0];
            use_fwd   <= 1'b0;
            if (need_flush) begin
              state     <= FLUSH;
              flush_cnt <= count;
            end else if (fwd_hit) begin
              state   <= RESP;
              use_fwd <= 1'b1;
              fwd_q   <= fwd_data;
            end else begin
              state <= RD;
            end
          end
        end
        FLUSH: begin
          // Snapshot down-counter: only entries older than the load drain here.
          if (flush_cnt <= CW'(1)) begin
            flush_cnt <= '0;
            state     <= RD;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        RD: state <= RESP;
        RESP: begin
          ld_data_q <= ld_data;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for store_buffer: directed stimulus queues expected memory
// writes, reads and load responses; a negedge monitor pops and compares them.
module tb_store_buffer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, st_ready, ld_valid, ld_ready, ld_done;
  logic [31:0]   st_addr, ld_addr, mem_addr;
  logic [DW-1:0] st_data, ld_data, mem_wdata, mem_rdata;
  logic          mem_write, mem_read;

  int checks;
  int failures;
  int cyc;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_done(ld_done), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Data_Memory stand-in: registered read, contents seeded on reset.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA0A0_0000 | i;
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= mem[mem_addr[3:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]    addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t q_ld[$];
  exp_t me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_push(input int kind, input logic [3:0] a, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    if (kind == 0) q_wr.push_back(e);
    else if (kind == 1) q_rd.push_back(e);
    else q_ld.push_back(e);
  endtask

  always @(negedge clk) begin
    chk("port_excl", {63'b0, mem_write & mem_read}, 64'd0);
    if (mem_write === 1'b1) begin
      if (q_wr.size() == 0) chk("unexpected_write", {60'b0, mem_addr[3:0]}, 64'hFFFF);
      else begin
        me = q_wr.pop_front();
        chk("wr_addr", mem_addr, {60'b0, me.addr});
        chk("wr_data", mem_wdata, me.data);
        chk("wr_cycle", cyc, me.cyc);
      end
    end
    if (mem_read === 1'b1) begin
      if (q_rd.size() == 0) chk("unexpected_read", {60'b0, mem_addr[3:0]}, 64'hFFFF);
      else begin
        me = q_rd.pop_front();
        chk("rd_addr", mem_addr, {60'b0, me.addr});
        chk("rd_cycle", cyc, me.cyc);
      end
    end
    if (ld_done === 1'b1) begin
      if (q_ld.size() == 0) chk("unexpected_ld_done", ld_data, 64'hFFFF_FFFF_FFFF);
      else begin
        me = q_ld.pop_front();
        chk("ld_data", ld_data, me.data);
        chk("ld_cycle", cyc, me.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [3:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [3:0] la);
    st_valid = sv;
    st_addr  = {28'h0, sa};
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = {28'h0, la};
    if (lv) chk("ld_ready_at_issue", {63'b0, ld_ready}, 64'd1);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_st_ready"}, {63'b0, st_ready}, 64'd1);
    chk({tag, "_ld_ready"}, {63'b0, ld_ready}, 64'd1);
    chk({tag, "_ld_done"}, {63'b0, ld_done}, 64'd0);
    chk({tag, "_ld_data"}, ld_data, 64'd0);
    chk({tag, "_mem_write"}, {63'b0, mem_write}, 64'd0);
    chk({tag, "_mem_read"}, {63'b0, mem_read}, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  int c;
  int acc;
  int exp_acc;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
    repeat (3) step();
    idle_outputs("reset");
    rst = 1'b0;
    step();

    // Plain store drains the cycle after acceptance.
    c = cyc;
    drive(1, 4'h2, 32'hDEADBEEF, 0, 4'h0);
    exp_push(0, 4'h2, 32'hDEADBEEF, c + 1);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("t1_drained", {63'b0, mem_write}, 64'd0);
    repeat (2) step();

    // Two stores to 0x0 buffered behind a load of 0x8, then a load of 0x0.
    c = cyc;
    drive(0, 0, 0, 1, 4'h8);
    exp_push(1, 4'h8, 0, c + 1);
    exp_push(2, 0, 32'hA0A00008, c + 2);
    step();
    drive(1, 4'h0, 32'h11111111, 0, 0);
    step();
    drive(1, 4'h0, 32'h22222222, 0, 0);
    step();
    drive(0, 0, 0, 1, 4'h0);
`ifdef STORE_BUF_FWD_EN
    exp_push(2, 0, 32'h22222222, c + 4);
    exp_push(0, 4'h0, 32'h11111111, c + 5);
    exp_push(0, 4'h0, 32'h22222222, c + 6);
`else
    exp_push(0, 4'h0, 32'h11111111, c + 4);
    exp_push(0, 4'h0, 32'h22222222, c + 5);
    exp_push(1, 4'h0, 0, c + 6);
    exp_push(2, 0, 32'h22222222, c + 7);
`endif
    step();
    drive(0, 0, 0, 0, 0);
    repeat (8) step();

    // Partial overlap 0x3 vs 0x5 forces a one-entry flush.
    c = cyc;
    drive(1, 4'h3, 32'hAAAAAAAA, 0, 0);
    step();
    drive(0, 0, 0, 1, 4'h5);
    exp_push(0, 4'h3, 32'hAAAAAAAA, c + 2);
    exp_push(1, 4'h5, 0, c + 3);
    exp_push(2, 0, 32'hA0A00005, c + 4);
    step();
    drive(0, 0, 0, 0, 0);
    repeat (6) step();

    // 0x0 vs 0x8 is exactly 8 apart: no overlap.
    c = cyc;
    drive(1, 4'h0, 32'h33333333, 0, 0);
    step();
    drive(0, 0, 0, 1, 4'h8);
`ifdef STORE_BUF_FWD_EN
    exp_push(1, 4'h8, 0, c + 2);
    exp_push(2, 0, 32'hA0A00008, c + 3);
    exp_push(0, 4'h0, 32'h33333333, c + 4);
`else
    exp_push(0, 4'h0, 32'h33333333, c + 2);
    exp_push(1, 4'h8, 0, c + 3);
    exp_push(2, 0, 32'hA0A00008, c + 4);
`endif
    step();
    drive(0, 0, 0, 0, 0);
    repeat (6) step();

    // Fill the FIFO while loads hold the port; 5th store waits for a pop.
    c = cyc;
    drive(1, 4'h0, 32'h50000001, 1, 4'h8);
    exp_push(1, 4'h8, 0, c + 1);
    exp_push(2, 0, 32'hA0A00008, c + 2);
    step();
    drive(1, 4'h0, 32'h50000002, 0, 0);
    step();
    drive(1, 4'h0, 32'h50000003, 0, 0);
    step();
    drive(1, 4'h0, 32'h50000004, 1, 4'h8);
`ifdef STORE_BUF_FWD_EN
    exp_push(1, 4'h8, 0, c + 4);
    exp_push(2, 0, 32'hA0A00008, c + 5);
    for (int i = 0; i < 5; i++) exp_push(0, 4'h0, 32'h50000001 + i, c + 6 + i);
    exp_acc = c + 7;
`else
    exp_push(0, 4'h0, 32'h50000001, c + 4);
    exp_push(0, 4'h0, 32'h50000002, c + 5);
    exp_push(0, 4'h0, 32'h50000003, c + 6);
    exp_push(1, 4'h8, 0, c + 7);
    exp_push(2, 0, 32'hA0A00008, c + 8);
    exp_push(0, 4'h0, 32'h50000004, c + 9);
    exp_push(0, 4'h0, 32'h50000005, c + 10);
    exp_acc = c + 5;
`endif
    step();
    drive(1, 4'h0, 32'h50000005, 0, 0);
    chk("t5_full_st_ready", {63'b0, st_ready}, 64'd0);
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (st_ready) begin
        acc = cyc;
        break;
      end
      step();
    end
    chk("t5_accept_cycle", acc, exp_acc);
    step();
    drive(0, 0, 0, 0, 0);
    repeat (10) step();

    // Reset during RD drops the load and the buffered store.
    c = cyc;
    drive(1, 4'h1, 32'h66666666, 1, 4'h8);
    exp_push(1, 4'h8, 0, c + 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t6_in_rd", {63'b0, mem_read}, 64'd1);
    rst = 1'b1;
    step();
    idle_outputs("rst_mid_load");
    rst = 1'b0;
    repeat (6) step();

    chk("q_wr_empty", q_wr.size(), 64'd0);
    chk("q_rd_empty", q_rd.size(), 64'd0);
    chk("q_ld_empty", q_ld.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required below 10000", cyc);
    $fatal(1);
  end

endmodule
